// File: rtl/arv_mem_pkg.sv
// Shared types and helpers for the byte-addressable data memory.
package arv_mem_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} mem_size_e;
  typedef enum logic {ST_CLEAR, ST_RUN} mem_state_e;

  // Byte-lane mask for an access of the given size starting at lane offset.
  function automatic logic [7:0] lane_mask(input mem_size_e sz, input logic [2:0] off);
    logic [7:0] base;
    case (sz)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// Request/response bus between the load/store unit and the data memory.
interface data_memory_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH*WIDTH/8)
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic             req_we_i;
  logic [AW-1:0]    req_addr_i;
  logic [1:0]       req_size_i;
  logic             req_unsigned_i;
  logic [WIDTH-1:0] req_wdata_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [WIDTH-1:0] rsp_rdata_o;
  logic             rsp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
    output rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
    input  rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/mem_byte_array.sv
// DEPTH x WIDTH storage with per-byte write strobes and an asynchronous read port.
module mem_byte_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH/8-1:0]       wstrb,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_memory.sv
// Byte-addressable data memory: post-reset clear sweep, aligned sub-word access, one-cycle response.
module data_memory
  import arv_mem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH*WIDTH/8)
) (
  input logic clk_i,
  input logic rst_i,
  data_memory_if.slave bus
);
  localparam int NB   = WIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int IW   = $clog2(DEPTH);

  if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
    $error("data_memory: WIDTH must be 32 or 64");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("data_memory: DEPTH must be a power of two >= 2");
  end

  function automatic logic [WIDTH-1:0] extend(input logic [WIDTH-1:0] v, input mem_size_e sz,
                                              input logic uns);
    case (sz)
      SZ_B:    return uns ? WIDTH'(v[7:0])  : WIDTH'($signed(v[7:0]));
      SZ_H:    return uns ? WIDTH'(v[15:0]) : WIDTH'($signed(v[15:0]));
      SZ_W:    return uns ? WIDTH'(v[31:0]) : WIDTH'($signed(v[31:0]));
      default: return v;
    endcase
  endfunction

  mem_state_e       state;
  logic [IW-1:0]    ptr;
  logic             rsp_vld_p1;
  logic [WIDTH-1:0] rsp_data_p1;
  logic             rsp_err_p1;

  mem_size_e          sz_p0;
  logic [OFFW-1:0]    off_p0;
  logic [AW-OFFW-1:0] word_idx_p0;
  logic [IW-1:0]      widx_p0;
  logic               misalign_p0, size_err_p0, range_err_p0, err_p0;
  logic               accept_p0, store_p0, clearing;
  logic [NB-1:0]      strb_p0;
  logic [WIDTH-1:0]   wdata_sh_p0, rd_word_p0, load_p0;
  logic               mem_we;
  logic [IW-1:0]      mem_waddr;
  logic [NB-1:0]      mem_wstrb;
  logic [WIDTH-1:0]   mem_wdata;

  // Stage p0: decode, check and route the incoming request
  assign sz_p0       = mem_size_e'(bus.req_size_i);
  assign off_p0      = bus.req_addr_i[OFFW-1:0];
  assign word_idx_p0 = bus.req_addr_i[AW-1:OFFW];
  assign widx_p0     = word_idx_p0[IW-1:0];

  always_comb begin
    misalign_p0 = 1'b0;
    case (sz_p0)
      SZ_H:    misalign_p0 = bus.req_addr_i[0];
      SZ_W:    misalign_p0 = bus.req_addr_i[1:0] != 2'b00;
      SZ_D:    misalign_p0 = bus.req_addr_i[2:0] != 3'b000;
      default: misalign_p0 = 1'b0;
    endcase
  end

  assign size_err_p0  = (sz_p0 == SZ_D) && (WIDTH == 32);
  // Only reachable if AW is widened beyond the storage size.
  assign range_err_p0 = 32'(word_idx_p0) >= 32'(DEPTH);
  assign err_p0       = misalign_p0 || size_err_p0 || range_err_p0;

  assign clearing        = (state == ST_CLEAR);
  assign bus.req_ready_o = (state == ST_RUN) && (!rsp_vld_p1 || bus.rsp_ready_i);
  assign accept_p0       = bus.req_valid_i && bus.req_ready_o;
  assign store_p0        = accept_p0 && bus.req_we_i && !err_p0;

  assign strb_p0     = NB'(lane_mask(sz_p0, 3'(off_p0)));
  assign wdata_sh_p0 = bus.req_wdata_i << {off_p0, 3'b000};

  assign mem_we    = clearing || store_p0;
  assign mem_waddr = clearing ? ptr : widx_p0;
  assign mem_wstrb = clearing ? {NB{1'b1}} : strb_p0;
  assign mem_wdata = clearing ? '0 : wdata_sh_p0;

  mem_byte_array #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_array (
    .clk   (clk_i),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wstrb (mem_wstrb),
    .wdata (mem_wdata),
    .raddr (widx_p0),
    .rdata (rd_word_p0)
  );

  assign load_p0 = extend(rd_word_p0 >> {off_p0, 3'b000}, sz_p0, bus.req_unsigned_i);

  // Stage p1: FSM and registered response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_CLEAR;
      ptr         <= '0;
      rsp_vld_p1  <= 1'b0;
      rsp_data_p1 <= '0;
      rsp_err_p1  <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == IW'(DEPTH - 1)) state <= ST_RUN;
        end
        default: begin
          if (accept_p0) begin
            rsp_vld_p1  <= 1'b1;
            rsp_data_p1 <= (err_p0 || bus.req_we_i) ? '0 : load_p0;
            rsp_err_p1  <= err_p0;
          end else if (rsp_vld_p1 && bus.rsp_ready_i) begin
            rsp_vld_p1 <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.rsp_valid_o = rsp_vld_p1;
  assign bus.rsp_rdata_o = rsp_data_p1;
  assign bus.rsp_err_o   = rsp_err_p1;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: directed loads/stores, errors, stall and reset recovery.
module tb_data_memory;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 6;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  data_memory_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) bus ();

  data_memory #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Drive one request, wait for acceptance, and queue its expected response.
  task automatic issue(input string nm, input logic we, input logic [AW-1:0] a,
                       input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                       input logic [31:0] ed, input logic ee);
    int n;
    exp_t e;
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = we;
    bus.req_addr_i     = a;
    bus.req_size_i     = sz;
    bus.req_unsigned_i = uns;
    bus.req_wdata_i    = wd;
    #1;
    n = 0;
    while (!bus.req_ready_o && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.req_ready_o) begin
      check({nm, " accept timeout"}, 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      e.name = nm;
      e.data = ed;
      e.err  = ee;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_clear(input string nm);
    int n;
    n = 0;
    while (!bus.req_ready_o && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(nm, 32'(n), 32'd16);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  // Monitor: compare every completed response handshake against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.rsp_valid_o && bus.rsp_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected response", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check({e.name, " rdata"}, bus.rsp_rdata_o, e.data);
          check({e.name, " err"}, 32'(bus.rsp_err_o), 32'(e.err));
        end
      end
    end
  end

  initial begin
    bus.req_valid_i    = 1'b0;
    bus.req_we_i       = 1'b0;
    bus.req_addr_i     = '0;
    bus.req_size_i     = 2'd0;
    bus.req_unsigned_i = 1'b0;
    bus.req_wdata_i    = '0;
    bus.rsp_ready_i    = 1'b1;

    repeat (3) @(negedge clk);
    check("reset req_ready", 32'(bus.req_ready_o), 32'd0);
    check("reset rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("reset rsp_rdata", bus.rsp_rdata_o, 32'd0);
    check("reset rsp_err", 32'(bus.rsp_err_o), 32'd0);
    rst = 1'b0;
    wait_clear("clear cycles");
    @(negedge clk);

    issue("ld w 0x3C cleared", 1'b0, 6'h3C, 2'd2, 1'b0, 32'h0, 32'h0000_0000, 1'b0);
    issue("st w 0x14", 1'b1, 6'h14, 2'd2, 1'b0, 32'h8000_00F0, 32'h0, 1'b0);
    issue("ld b signed 0x14", 1'b0, 6'h14, 2'd0, 1'b0, 32'h0, 32'hFFFF_FFF0, 1'b0);
    issue("ld b unsigned 0x14", 1'b0, 6'h14, 2'd0, 1'b1, 32'h0, 32'h0000_00F0, 1'b0);
    issue("st w 0x14 base", 1'b1, 6'h14, 2'd2, 1'b0, 32'h1122_3344, 32'h0, 1'b0);
    issue("st h 0x16", 1'b1, 6'h16, 2'd1, 1'b0, 32'hFFFF_BEEF, 32'h0, 1'b0);
    issue("ld w 0x14 merged", 1'b0, 6'h14, 2'd2, 1'b0, 32'h0, 32'hBEEF_3344, 1'b0);
    issue("ld h 0x15 misaligned", 1'b0, 6'h15, 2'd1, 1'b0, 32'h0, 32'h0, 1'b1);
    issue("st w 0x16 misaligned", 1'b1, 6'h16, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b1);
    issue("st d 0x18 bad size", 1'b1, 6'h18, 2'd3, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b1);
    issue("ld w 0x14 unchanged", 1'b0, 6'h14, 2'd2, 1'b0, 32'h0, 32'hBEEF_3344, 1'b0);
    issue("st b 0x3F top", 1'b1, 6'h3F, 2'd0, 1'b0, 32'h0000_00A5, 32'h0, 1'b0);
    issue("ld b unsigned 0x3F", 1'b0, 6'h3F, 2'd0, 1'b1, 32'h0, 32'h0000_00A5, 1'b0);
    issue("ld h signed 0x3E", 1'b0, 6'h3E, 2'd1, 1'b0, 32'h0, 32'hFFFF_A500, 1'b0);
    issue("ld w 0x18 untouched", 1'b0, 6'h18, 2'd2, 1'b0, 32'h0, 32'h0000_0000, 1'b0);
    drain();

    // Response stall: hold rsp_ready low with a second request waiting.
    bus.rsp_ready_i = 1'b0;
    issue("ld w 0x14 stalled", 1'b0, 6'h14, 2'd2, 1'b0, 32'h0, 32'hBEEF_3344, 1'b0);
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = 1'b0;
    bus.req_addr_i     = 6'h14;
    bus.req_size_i     = 2'd0;
    bus.req_unsigned_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
      check("stall rsp_rdata", bus.rsp_rdata_o, 32'hBEEF_3344);
      check("stall req_ready", 32'(bus.req_ready_o), 32'd0);
      @(negedge clk);
    end
    bus.rsp_ready_i = 1'b1;
    #1;
    check("release req_ready", 32'(bus.req_ready_o), 32'd1);
    begin
      exp_t e;
      @(posedge clk);
      e.name = "ld b unsigned queued";
      e.data = 32'h0000_0044;
      e.err  = 1'b0;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    drain();

    // Reset while a response is held: it must vanish and the array must be swept.
    bus.rsp_ready_i = 1'b0;
    issue("ld w dropped", 1'b0, 6'h14, 2'd2, 1'b0, 32'h0, 32'hBEEF_3344, 1'b0);
    #1;
    check("held before reset", 32'(bus.rsp_valid_o), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid-reset rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("mid-reset req_ready", 32'(bus.req_ready_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.rsp_ready_i = 1'b1;
    wait_clear("re-clear cycles");
    @(negedge clk);
    issue("ld w 0x14 after reset", 1'b0, 6'h14, 2'd2, 1'b0, 32'h0, 32'h0000_0000, 1'b0);
    issue("ld b 0x3F after reset", 1'b0, 6'h3F, 2'd0, 1'b1, 32'h0, 32'h0000_0000, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
